// File: rtl/generador_de_secuencia.sv
// Serial pattern generator: shifts a captured pattern MSB-first onto w,
// optionally looping, with a one-cycle DONE pulse after a single pass.
// Every output is registered; the next-output values come from the
// next-state decode so no input reaches an output without a flop.
//
// Handshake: start is sampled on the rising edge while the FSM is in IDLE
// or DONE; a legal request (1 <= len <= WIDTH) is taken in that same edge.
// There is no backpressure. w is meaningful only while w_valid is 1.
// stop outranks start in every state.
// The loop request input is named repeat_en because "repeat" is a
// reserved word in SystemVerilog.
module generador_de_secuencia #(
    parameter  int WIDTH = 8,
    localparam int LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [LW-1:0]    len_q;
    logic             rpt_q;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             load;
    logic             len_legal;

    logic             w_d, w_valid_d, busy_d, done_d;
    logic [WIDTH-1:0] bit_src;
    logic [WIDTH-1:0] bit_shifted;

    assign len_legal = (len != '0) && (len <= LW'(WIDTH));
    assign dbg_state = state_q;

    // State, bit counter and captured request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                data_q <= data;
                len_q  <= len;
                rpt_q  <= repeat_en;
            end
        end
    end

    // Next-state decode; cnt is the index of the bit that will be on w.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop && len_legal) begin
                    state_d = S_SHIFT;
                    load    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (rpt_q) begin
                        cnt_d = len_q - LW'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            S_DONE: begin
                if (!stop && start && len_legal) begin
                    state_d = S_SHIFT;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            cnt_d = len - LW'(1);
        end
    end

    // Next-output decode from the state being entered.
    always_comb begin
        w_d         = 1'b0;
        w_valid_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        bit_src     = load ? data : data_q;
        bit_shifted = bit_src >> cnt_d;
        case (state_d)
            S_SHIFT: begin
                w_d       = bit_shifted[0];
                w_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                w_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            w       <= w_d;
            w_valid <= w_valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_generador_de_secuencia.sv
// Bench for generador_de_secuencia: random and directed transactions,
// a queue-based scoreboard fed by a pattern model, and a small Mealy
// "1011" detector driven by the serial output.
module tb_generador_de_secuencia;

    localparam int WIDTH = 8;
    localparam int LW    = 4;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [LW-1:0]    len;
    logic             repeat_en;
    logic             stop;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    generador_de_secuencia #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .data      (data),
        .len       (len),
        .repeat_en (repeat_en),
        .stop      (stop),
        .w         (w),
        .w_valid   (w_valid),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    // Entry encoding: 2'b00 / 2'b01 = serial bit 0 / 1, 2'b10 = done pulse.
    logic [1:0] exp_q[$];
    int         n_cmp;
    int         n_fail;
    logic [1:0] got_m;
    logic [1:0] exp_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Mealy detector for "1011" ----------------
    logic [2:0] hist;
    logic       z;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     hist <= 3'b000;
        else if (w_valid) hist <= {hist[1:0], w};
        else              hist <= 3'b000;
    end
    assign z = w_valid && w && (hist == 3'b101);

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n && (w_valid || done)) begin
            got_m = {done, w_valid ? w : 1'b0};
            if (done && w_valid) got_m = 2'b11;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected nothing at %0t", got_m, $time);
            end else begin
                exp_m = exp_q.pop_front();
                check("sb_out", {30'd0, got_m}, {30'd0, exp_m});
            end
            check("sb_busy", {31'd0, busy}, 32'd1);
        end
    end

    // ---------------- model ----------------
    task automatic push_stream(input logic [7:0] d, input int l, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back({1'b0, d[l - 1 - (i % l)]});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble(input bit en, input bit with_start);
        if (en) begin
            data      = WIDTH'($urandom);
            len       = LW'($urandom);
            repeat_en = 1'($urandom);
            start     = with_start ? 1'($urandom) : 1'b0;
        end
    endtask

    // stop_at < 0: no stop; otherwise stop is applied while bit number
    // stop_at (0-based, counting through repeats) is on w.
    task automatic run_txn(input logic [7:0] d, input int l, input logic r,
                           input int stop_at, input bit garbage);
        bit legal;
        legal     = (l >= 1) && (l <= WIDTH);
        data      = d;
        len       = LW'(l);
        repeat_en = r;
        start     = 1'b1;
        if (legal) begin
            if (stop_at >= 0) push_stream(d, l, stop_at + 1);
            else begin
                push_stream(d, l, l);
                exp_q.push_back(2'b10);
            end
        end
        step();
        start = 1'b0;
        if (!legal) begin
            check("illegal_busy", {31'd0, busy}, 32'd0);
            check("illegal_valid", {31'd0, w_valid}, 32'd0);
            check("illegal_done", {31'd0, done}, 32'd0);
            step();
            check("illegal_busy2", {31'd0, busy}, 32'd0);
            return;
        end
        check("latency_valid", {31'd0, w_valid}, 32'd1);
        if (stop_at >= 0) begin
            for (int k = 0; k < stop_at; k++) begin
                scramble(garbage, 1'b1);
                step();
            end
            start = 1'b0;
            stop  = 1'b1;
            step();
            stop  = 1'b0;
            check("stop_busy", {31'd0, busy}, 32'd0);
            check("stop_valid", {31'd0, w_valid}, 32'd0);
            check("stop_done", {31'd0, done}, 32'd0);
        end else begin
            for (int k = 0; k < l; k++) begin
                scramble(garbage, 1'b1);
                step();
            end
            start = 1'b0;
            check("done_pulse", {31'd0, done}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd1);
            step();
            check("end_busy", {31'd0, busy}, 32'd0);
            check("end_done", {31'd0, done}, 32'd0);
        end
        check("sb_drain", exp_q.size(), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] rd;
        int         rl;
        logic       rr;
        int         rs;
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        data      = '0;
        len       = '0;
        repeat_en = 1'b0;

        #12;
        check("rst_w", {31'd0, w}, 32'd0);
        check("rst_valid", {31'd0, w_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        step();
        reset_n = 1'b1;

        // Known 8-bit pattern, single pass.
        run_txn(8'b1011_0010, 8, 1'b0, -1, 1'b0);
        // Repeating "111" with scrambled inputs, then stop.
        run_txn(8'hFF, 3, 1'b1, 24, 1'b1);
        // Illegal lengths.
        run_txn(8'hA5, 0, 1'b0, -1, 1'b0);
        run_txn(8'hA5, 9, 1'b0, -1, 1'b0);
        // stop in IDLE is harmless; stop outranks start.
        stop  = 1'b1;
        start = 1'b1;
        len   = 4'd3;
        step();
        stop  = 1'b0;
        start = 1'b0;
        check("stop_over_start", {31'd0, busy}, 32'd0);
        // len = 1 single pass and held repeat.
        run_txn(8'h01, 1, 1'b0, -1, 1'b0);
        run_txn(8'h01, 1, 1'b1, 6, 1'b0);

        // Back-to-back: restart accepted in the DONE cycle.
        push_stream(8'h05, 3, 3);
        exp_q.push_back(2'b10);
        push_stream(8'h06, 3, 3);
        exp_q.push_back(2'b10);
        data  = 8'h05;
        len   = 4'd3;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_gap", {31'd0, w_valid}, 32'd0);
        data  = 8'h06;
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_first_valid", {31'd0, w_valid}, 32'd1);
        check("b2b_first_w", {31'd0, w}, 32'd1);
        step();
        step();
        step();
        check("b2b_done2", {31'd0, done}, 32'd1);
        step();
        check("b2b_drain", exp_q.size(), 32'd0);

        // Asynchronous reset while the fifth bit is on w.
        rd = 8'($urandom);
        push_stream(rd, 8, 4);
        data  = rd;
        len   = 4'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("arst_w", {31'd0, w}, 32'd0);
        check("arst_valid", {31'd0, w_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        step();
        step();
        check("arst_drain", exp_q.size(), 32'd0);
        reset_n = 1'b1;
        run_txn(8'h96, 8, 1'b0, -1, 1'b0);

        // Closed loop with the "1011" detector.
        push_stream(8'h0B, 4, 4);
        exp_q.push_back(2'b10);
        data  = 8'h0B;
        len   = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        check("det_z0", {31'd0, z}, 32'd0);
        step();
        check("det_z1", {31'd0, z}, 32'd0);
        step();
        check("det_z2", {31'd0, z}, 32'd0);
        step();
        check("det_hit", {31'd0, z}, 32'd1);
        step();
        step();
        push_stream(8'h09, 4, 4);
        exp_q.push_back(2'b10);
        data  = 8'h09;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("det_nomatch", {31'd0, z}, 32'd0);
            step();
        end
        step();
        check("det_drain", exp_q.size(), 32'd0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            rd = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
            else rl = $urandom_range(1, 8);
            rr = 1'($urandom_range(0, 1));
            if (rr) rs = $urandom_range(0, 20);
            else if ($urandom_range(0, 1) == 1 && rl >= 1 && rl <= 8) rs = $urandom_range(0, rl - 1);
            else rs = -1;
            run_txn(rd, rl, rr, rs, 1'($urandom_range(0, 1)));
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/generador_de_secuencia.md
GENERADOR_DE_SECUENCIA -- requirements
Module: generador_de_secuencia

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits (WIDTH >= 2).
REQ-002 The block SHALL have derived width LW = ceil(log2(WIDTH))+1, the width of the length field (4 for WIDTH=8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, a request to transmit the pattern on data/len.
REQ-006 The block SHALL have port data, input, WIDTH bits, the pattern; only bits [len-1:0] are transmitted.
REQ-007 The block SHALL have port len, input, LW bits, the pattern length in bits; legal range 1..WIDTH.
REQ-008 The block SHALL have port repeat, input, 1 bit, sampled with start; when 1, the pattern loops continuously.
REQ-009 The block SHALL have port stop, input, 1 bit, aborting any transmission in progress.
REQ-010 The block SHALL have port w, output, 1 bit, the serial pattern bit feeding the Mealy detector input w.
REQ-011 The block SHALL have port w_valid, output, 1 bit, high while w carries a pattern bit.
REQ-012 The block SHALL have port busy, output, 1 bit, high in states SHIFT and DONE.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last bit of a non-repeating transmission.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE; all outputs SHALL be registered (no combinational input-to-output path).
REQ-015 In IDLE, outputs SHALL be w=0, w_valid=0, busy=0 and done=0.
REQ-016 In IDLE, start=1 with 1<=len<=WIDTH SHALL capture data, len and repeat into internal registers and move the FSM to SHIFT.
REQ-017 In IDLE, start=1 with len=0 or len>WIDTH SHALL be ignored; the FSM SHALL remain in IDLE with no output change.
REQ-018 Latency SHALL be 1 cycle: the first bit, data[len-1], SHALL be on w with w_valid=1 in the cycle after the start edge.
REQ-019 In SHIFT, bits SHALL be sent MSB-first, one per cycle: data[len-1], data[len-2], ... data[0]; a bit counter SHALL go from len-1 down to 0.
REQ-020 In SHIFT, start, data, len and repeat changes SHALL be ignored; the captured copies are used.
REQ-021 After bit 0 with captured repeat=0, the FSM SHALL enter DONE for exactly one cycle with done=1, w_valid=0, w=0 and busy=1, and SHALL then return to IDLE.
REQ-022 After bit 0 with captured repeat=1, the next cycle SHALL carry captured bit len-1 again, with no gap and no done pulse.
REQ-023 start=1 (legal len) during the DONE cycle SHALL be accepted: the FSM goes to SHIFT and the new first bit appears the next cycle (one-cycle gap between patterns).
REQ-024 stop=1 in SHIFT or DONE SHALL force IDLE at the next edge with w=0 and w_valid=0, and SHALL suppress done.
REQ-025 stop has priority over start; stop=1 in IDLE SHALL have no effect.
REQ-026 With len=1, a single bit data[0] SHALL be sent followed by DONE; with repeat=1 and len=1, w SHALL be held at data[0] every cycle.

Reset
REQ-027 reset_n=0 SHALL immediately, without a clock edge, force state IDLE, w=0, w_valid=0, busy=0, done=0, and SHALL clear the captured data, length, repeat and counter registers.
REQ-028 Reset asserted mid-transmission SHALL abort it with no done pulse.
REQ-029 After release, the first start SHALL be honoured on the first rising edge at which reset_n=1.

Verification
REQ-030 WIDTH=8; start pulse, data=8'b1011_0010, len=8, repeat=0 -> w = 1,0,1,1,0,0,1,0 on cycles 1..8 with w_valid=1; done=1 on cycle 9; IDLE on cycle 10.
REQ-031 data=8'hFF, len=3, repeat=1 -> w=1 and w_valid=1 continuously for 20+ cycles with no done; then stop=1 -> w_valid=0 and busy=0 at the next edge, no done.
REQ-032 start with len=0, and separately with len=9 -> busy, w_valid and done stay 0.
REQ-033 data=8'h05, len=3 ("101"), then a second start with data=8'h06, len=3 during the DONE cycle -> w = 1,0,1, gap, 1,1,0; exactly two done pulses.
REQ-034 reset_n=0 asynchronously during bit 4 of an 8-bit pattern -> all outputs 0 before the next clk edge; no done; a start after release transmits normally.
REQ-035 Closed loop with the Mealy detector: the bench feeds w into the detector and drives the known detect pattern -> detector z=1 on the cycle the final bit is present, and z=0 for a non-matching pattern.
